// File: rtl/tron_pkg.sv
// rtl/tron_pkg.sv - frame buffer geometry, colour codes and trail writer states
package tron_pkg;

    localparam int unsigned H_WORDS = 320;
    localparam int unsigned V_LINES = 480;
    localparam int unsigned CELL    = 4;
    localparam int unsigned GRID_W  = 160;
    localparam int unsigned GRID_H  = 120;

    localparam logic [3:0] BLUE_CODE = 4'h6;
    localparam logic [3:0] RED_CODE  = 4'h4;
    localparam logic [3:0] BG_CODE   = 4'h8;

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        LATCH,
        WR_BLUE,
        WR_RED
    } tw_state_t;

    // Two pixels per word, each a 4-bit colour in the low nibble of its byte.
    function automatic logic [15:0] pix_word(input logic [3:0] code);
        return {4'h0, code, 4'h0, code};
    endfunction

endpackage

// File: rtl/frame_edge_sync.sv
// rtl/frame_edge_sync.sv - two-flop synchroniser and rising-edge pulse for the frame tick
module frame_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic pulse
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign pulse = s2 & ~s3;

endmodule

// File: rtl/trail_writer.sv
// rtl/trail_writer.sv - frameRAM write side: background fill and per-frame bike cell stamping
module trail_writer #(
    parameter int unsigned H_WORDS = tron_pkg::H_WORDS,
    parameter int unsigned V_LINES = tron_pkg::V_LINES
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        clear,
    input  logic [9:0]  Blue_X_real,
    input  logic [9:0]  Blue_Y_real,
    input  logic [9:0]  Red_X_real,
    input  logic [9:0]  Red_Y_real,
    input  logic        blue_en,
    input  logic        red_en,
    output logic        WE,
    output logic [18:0] write_address,
    output logic [15:0] Data_In,
    output logic        busy,
    output logic        clear_done,
    output logic        overrun
);

    import tron_pkg::*;

    localparam logic [9:0]  X_LIM     = 10'(H_WORDS * 2 / CELL);
    localparam logic [9:0]  Y_LIM     = 10'(V_LINES / CELL);
    localparam logic [17:0] FILL_LAST = 18'(H_WORDS * V_LINES - 1);

    function automatic logic [18:0] cell_addr(input logic [9:0] x, input logic [9:0] y,
                                              input logic [1:0] r, input logic j);
        logic [19:0] a;
        a = {9'd0, x, 1'b0} + {19'd0, j}
            + ({10'd0, y} * 20'(CELL) + {18'd0, r}) * 20'(H_WORDS);
        return a[18:0];
    endfunction

    tw_state_t   state, nxt;
    logic        tick;
    logic [17:0] fill_q, fill_d;
    logic [1:0]  row_q, row_d;
    logic        word_q, word_d;
    logic        last_q, last_d;
    logic [9:0]  bx_q, by_q, rx_q, ry_q;
    logic        ben_q, ren_q;

    logic [9:0]  bx_c, by_c, rx_c, ry_c;
    logic        bv, rv, emit, ovr;
    logic [2:0]  idx_n;
    logic [18:0] e_addr;
    logic [15:0] e_data;

    frame_edge_sync u_sync (
        .clk      (Clk),
        .rst_n    (Reset),
        .async_in (frame_clk),
        .pulse    (tick)
    );

    // In LATCH the snapshot is being taken this very cycle, so the first write uses live inputs.
    always_comb begin
        bx_c  = (state == LATCH) ? Blue_X_real : bx_q;
        by_c  = (state == LATCH) ? Blue_Y_real : by_q;
        rx_c  = (state == LATCH) ? Red_X_real  : rx_q;
        ry_c  = (state == LATCH) ? Red_Y_real  : ry_q;
        bv    = ((state == LATCH) ? blue_en : ben_q) && (bx_c < X_LIM) && (by_c < Y_LIM);
        rv    = ((state == LATCH) ? red_en  : ren_q) && (rx_c < X_LIM) && (ry_c < Y_LIM);
        idx_n = {row_q, word_q} + 3'd1;
    end

    always_comb begin
        nxt    = state;
        emit   = 1'b0;
        e_addr = write_address;
        e_data = Data_In;
        fill_d = fill_q;
        row_d  = row_q;
        word_d = word_q;
        last_d = 1'b0;
        ovr    = 1'b0;
        case (state)
            CLEAR: begin
                emit   = 1'b1;
                e_addr = {1'b0, fill_q};
                e_data = pix_word(BG_CODE);
                if (fill_q == FILL_LAST) begin
                    nxt    = IDLE;
                    fill_d = '0;
                    last_d = 1'b1;
                end else begin
                    fill_d = fill_q + 18'd1;
                end
            end
            IDLE: begin
                if (clear)     nxt = CLEAR;
                else if (tick) nxt = LATCH;
            end
            LATCH: begin
                row_d  = 2'd0;
                word_d = 1'b0;
                if (bv) begin
                    emit   = 1'b1;
                    e_addr = cell_addr(bx_c, by_c, 2'd0, 1'b0);
                    e_data = pix_word(BLUE_CODE);
                    nxt    = WR_BLUE;
                end else if (rv) begin
                    emit   = 1'b1;
                    e_addr = cell_addr(rx_c, ry_c, 2'd0, 1'b0);
                    e_data = pix_word(RED_CODE);
                    nxt    = WR_RED;
                end else begin
                    nxt = IDLE;
                end
            end
            WR_BLUE: begin
                if (clear) begin
                    nxt = CLEAR;
                end else if (row_q == 2'd3 && word_q) begin
                    row_d  = 2'd0;
                    word_d = 1'b0;
                    if (rv) begin
                        emit   = 1'b1;
                        e_addr = cell_addr(rx_c, ry_c, 2'd0, 1'b0);
                        e_data = pix_word(RED_CODE);
                        nxt    = WR_RED;
                    end else begin
                        nxt = IDLE;
                    end
                end else begin
                    emit            = 1'b1;
                    {row_d, word_d} = idx_n;
                    e_addr          = cell_addr(bx_c, by_c, idx_n[2:1], idx_n[0]);
                    e_data          = pix_word(BLUE_CODE);
                end
            end
            WR_RED: begin
                if (clear) begin
                    nxt = CLEAR;
                end else if (row_q == 2'd3 && word_q) begin
                    row_d  = 2'd0;
                    word_d = 1'b0;
                    nxt    = IDLE;
                end else begin
                    emit            = 1'b1;
                    {row_d, word_d} = idx_n;
                    e_addr          = cell_addr(rx_c, ry_c, idx_n[2:1], idx_n[0]);
                    e_data          = pix_word(RED_CODE);
                end
            end
            default: nxt = IDLE;
        endcase
        // Ticks are only accepted in IDLE with no competing clear; anything else is dropped.
        if (tick && !(state == IDLE && !clear)) ovr = 1'b1;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state         <= CLEAR;
            fill_q        <= '0;
            row_q         <= '0;
            word_q        <= 1'b0;
            last_q        <= 1'b0;
            bx_q          <= '0;
            by_q          <= '0;
            rx_q          <= '0;
            ry_q          <= '0;
            ben_q         <= 1'b0;
            ren_q         <= 1'b0;
            WE            <= 1'b0;
            write_address <= '0;
            Data_In       <= '0;
            busy          <= 1'b0;
            clear_done    <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            state      <= nxt;
            fill_q     <= fill_d;
            row_q      <= row_d;
            word_q     <= word_d;
            last_q     <= last_d;
            WE         <= emit;
            busy       <= (nxt != IDLE);
            clear_done <= last_q;
            overrun    <= ovr;
            if (emit) begin
                write_address <= e_addr;
                Data_In       <= e_data;
            end
            if (state == LATCH) begin
                bx_q  <= Blue_X_real;
                by_q  <= Blue_Y_real;
                rx_q  <= Red_X_real;
                ry_q  <= Red_Y_real;
                ben_q <= blue_en;
                ren_q <= red_en;
            end
        end
    end

endmodule

// File: tb/tb_trail_writer.sv
// tb/tb_trail_writer.sv - scoreboard bench for trail_writer on a reduced-height frame buffer
module tb_trail_writer;

    localparam int TB_H  = 320;
    localparam int TB_V  = 96;
    localparam int TB_GW = 160;
    localparam int TB_GH = TB_V / 4;
    localparam int FILL  = TB_H * TB_V;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_clk;
    logic        clear;
    logic [9:0]  Blue_X_real, Blue_Y_real, Red_X_real, Red_Y_real;
    logic        blue_en, red_en;
    logic        WE;
    logic [18:0] write_address;
    logic [15:0] Data_In;
    logic        busy, clear_done, overrun;

    trail_writer #(.H_WORDS(TB_H), .V_LINES(TB_V)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .frame_clk     (frame_clk),
        .clear         (clear),
        .Blue_X_real   (Blue_X_real),
        .Blue_Y_real   (Blue_Y_real),
        .Red_X_real    (Red_X_real),
        .Red_Y_real    (Red_Y_real),
        .blue_en       (blue_en),
        .red_en        (red_en),
        .WE            (WE),
        .write_address (write_address),
        .Data_In       (Data_In),
        .busy          (busy),
        .clear_done    (clear_done),
        .overrun       (overrun)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [18:0] addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        int bx, by, rx, ry;
        bit ben, ren;
        int exp_writes;
    } vec_t;

    wr_t  expq[$];
    int   checks   = 0;
    int   failures = 0;
    int   cd_cnt   = 0;
    int   ov_cnt   = 0;
    int   wr_cnt   = 0;
    bit   mon_en   = 1'b1;

    always @(negedge Clk) begin
        if (Reset) begin
            if (clear_done) cd_cnt++;
            if (overrun)    ov_cnt++;
        end
        if (mon_en && WE) begin
            wr_t e;
            wr_cnt++;
            checks++;
            if (expq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write addr=%0d data=%h", write_address, Data_In);
            end else begin
                e = expq.pop_front();
                if (write_address !== e.addr || Data_In !== e.data) begin
                    failures++;
                    $display("FAIL write got addr=%0d data=%h expected addr=%0d data=%h",
                             write_address, Data_In, e.addr, e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic push_bike(input int x, input int y, input bit en, input logic [3:0] code,
                             input int nmax);
        int n = 0;
        if (en && x < TB_GW && y < TB_GH)
            for (int r = 0; r < 4; r++)
                for (int j = 0; j < 2; j++)
                    if (n < nmax) begin
                        expq.push_back('{addr: 19'(2 * x + j + (4 * y + r) * TB_H),
                                         data: {4'h0, code, 4'h0, code}});
                        n++;
                    end
    endtask

    task automatic push_fill();
        for (int i = 0; i < FILL; i++) expq.push_back('{addr: 19'(i), data: 16'h0808});
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while ((expq.size() != 0 || busy) && n < budget) begin
            @(negedge Clk);
            n++;
        end
        check({name, "_pending"}, expq.size(), 0);
        repeat (2) @(negedge Clk);
        check({name, "_busy"}, busy, 0);
    endtask

    task automatic set_bikes(input int bx, input int by, input int rx, input int ry,
                             input bit be, input bit re);
        Blue_X_real = 10'(bx);
        Blue_Y_real = 10'(by);
        Red_X_real  = 10'(rx);
        Red_Y_real  = 10'(ry);
        blue_en     = be;
        red_en      = re;
    endtask

    vec_t vecs[8];

    initial begin
        int cd0, ov0, wr0, n;
        vecs[0] = '{10, 20, 0, 0, 1, 0, 8};
        vecs[1] = '{0, 0, 0, 0, 1, 1, 16};
        vecs[2] = '{160, 5, 159, 23, 1, 1, 8};
        vecs[3] = '{5, 24, 7, 3, 1, 1, 8};
        vecs[4] = '{3, 3, 4, 4, 0, 0, 0};
        vecs[5] = '{50, 10, 50, 10, 0, 1, 8};
        vecs[6] = '{159, 23, 0, 0, 1, 1, 16};
        vecs[7] = '{1023, 2, 2, 1023, 1, 1, 0};

        Reset = 1'b0;
        frame_clk = 1'b0;
        clear = 1'b0;
        set_bikes(0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge Clk);
        check("rst_we", WE, 0);
        check("rst_addr", write_address, 0);
        check("rst_data", Data_In, 0);
        check("rst_busy", busy, 0);
        check("rst_clear_done", clear_done, 0);
        check("rst_overrun", overrun, 0);

        push_fill();
        Reset = 1'b1;
        @(negedge Clk);
        check("fill_busy", busy, 1);
        wait_idle(FILL + 50, "powerup_fill");
        check("powerup_clear_done", cd_cnt, 1);

        for (int i = 0; i < 8; i++) begin
            set_bikes(vecs[i].bx, vecs[i].by, vecs[i].rx, vecs[i].ry, vecs[i].ben, vecs[i].ren);
            push_bike(vecs[i].bx, vecs[i].by, vecs[i].ben, 4'h6, 8);
            push_bike(vecs[i].rx, vecs[i].ry, vecs[i].ren, 4'h4, 8);
            ov0 = ov_cnt;
            wr0 = wr_cnt;
            frame_clk = 1'b1;
            if (i == 0) begin
                repeat (3) begin
                    @(negedge Clk);
                    check("latency_pre", WE, 0);
                end
                @(negedge Clk);
                check("latency_first", WE, 1);
            end else begin
                repeat (4) @(negedge Clk);
            end
            set_bikes($urandom_range(0, 159), $urandom_range(0, 23), $urandom_range(0, 159),
                      $urandom_range(0, 23), 1'b1, 1'b1);
            frame_clk = 1'b0;
            wait_idle(200, "frame");
            check("frame_writes", wr_cnt - wr0, vecs[i].exp_writes);
            check("frame_no_overrun", ov_cnt - ov0, 0);
        end

        set_bikes(0, 0, 0, 0, 1, 1);
        push_bike(0, 0, 1, 4'h6, 8);
        push_bike(0, 0, 1, 4'h4, 8);
        ov0 = ov_cnt;
        wr0 = wr_cnt;
        frame_clk = 1'b1;
        repeat (2) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (2) @(negedge Clk);
        frame_clk = 1'b1;
        repeat (4) @(negedge Clk);
        frame_clk = 1'b0;
        wait_idle(200, "double_tick");
        check("double_tick_overrun", ov_cnt - ov0, 1);
        check("double_tick_writes", wr_cnt - wr0, 16);

        set_bikes(2, 2, 5, 5, 1, 1);
        push_bike(2, 2, 1, 4'h6, 3);
        cd0 = cd_cnt;
        frame_clk = 1'b1;
        repeat (4) @(negedge Clk);
        frame_clk = 1'b0;
        n = 0;
        while (expq.size() != 0 && n < 100) begin
            @(negedge Clk);
            #1;
            n++;
        end
        check("abort_three_writes", expq.size(), 0);
        push_fill();
        clear = 1'b1;
        repeat (2) @(negedge Clk);
        clear = 1'b0;
        repeat (100) @(negedge Clk);
        clear = 1'b1;
        @(negedge Clk);
        clear = 1'b0;
        wait_idle(FILL + 300, "abort_fill");
        check("abort_clear_done", cd_cnt - cd0, 1);

        set_bikes(1, 1, 0, 0, 1, 0);
        push_bike(1, 1, 1, 4'h6, 8);
        frame_clk = 1'b1;
        repeat (5) @(negedge Clk);
        mon_en = 1'b0;
        #1 Reset = 1'b0;
        #1;
        check("midop_rst_we", WE, 0);
        check("midop_rst_addr", write_address, 0);
        check("midop_rst_data", Data_In, 0);
        check("midop_rst_busy", busy, 0);
        expq.delete();
        frame_clk = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        check("refill_we", WE, 1);
        check("refill_addr", write_address, 0);
        check("refill_data", Data_In, 16'h0808);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
